alu_seq: RTL and testbench

//  Parametrised successor of the lab 6-bit load/compute ALU. Operands and

---
 rtl/alu_seq.sv | 199 +++++++++++++++++++
 tb/tb_alu_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential load/compute ALU: operands and function code are loaded serially,
// results are registered, and MUL/DIVU/REMU iterate one bit per cycle.
module alu_seq #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             ld,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             of,
   output logic             cf,
   output logic             zf,
   output logic             sf,
   output logic             busy,
   output logic             valid
);

   localparam int SW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER} state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     a_q, b_q, x_q, opnd_q, y_q;
   logic [3:0]           func_q;
   logic [1:0]           sel_q;
   logic                 ld_q, ld_prev_q, divz_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [CW-1:0]        cnt_q;
   logic                 of_q, cf_q, zf_q, sf_q, busy_q, valid_q;

   logic [WIDTH:0]       add_w, sub_w, mul_sum, div_shift, div_diff;
   logic [SW-1:0]        shamt;
   logic [WIDTH-1:0]     alu_y, fin_y;
   logic                 alu_of, alu_cf, fin_of, fin_cf, is_multi;
   logic [2*WIDTH-1:0]   acc_d;

   // Single-cycle operations, evaluated from the (stable) operand registers.
   always_comb begin
      add_w  = {1'b0, a_q} + {1'b0, b_q};
      sub_w  = {1'b0, a_q} - {1'b0, b_q};
      shamt  = b_q[SW-1:0];
      alu_y  = '0;
      alu_of = 1'b0;
      alu_cf = 1'b0;
      case (func_q)
         4'd0: begin
            alu_y  = add_w[WIDTH-1:0];
            alu_cf = add_w[WIDTH];
            alu_of = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         4'd1: begin
            alu_y  = sub_w[WIDTH-1:0];
            alu_cf = sub_w[WIDTH];
            alu_of = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         4'd2:  alu_y = a_q & b_q;
         4'd3:  alu_y = a_q | b_q;
         4'd4:  alu_y = a_q ^ b_q;
         4'd5:  alu_y = ~a_q;
         4'd6:  alu_y = a_q << shamt;
         4'd7:  alu_y = a_q >> shamt;
         4'd8:  alu_y = $signed(a_q) >>> shamt;
         4'd9:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         4'd10: alu_y = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
         4'd11: alu_y = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
         4'd15: alu_y = b_q;
         default: alu_y = '0;
      endcase
   end

   // One iteration step. MUL keeps {high, low} of the product in acc;
   // DIVU/REMU keep {remainder, quotient} and shift the dividend out of the low half.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd_q};
      if (func_q == 4'd12)
         acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      else if (!div_diff[WIDTH])
         acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
         acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      is_multi = (func_q == 4'd12) || (func_q == 4'd13) || (func_q == 4'd14);
      fin_y    = alu_y;
      fin_of   = alu_of;
      fin_cf   = alu_cf;
      if (state_q == S_ITER) begin
         fin_cf = 1'b0;
         case (func_q)
            4'd12: begin
               fin_y  = acc_d[WIDTH-1:0];
               fin_of = |acc_d[2*WIDTH-1:WIDTH];
            end
            4'd13: begin
               fin_y  = acc_d[WIDTH-1:0];
               fin_of = divz_q;
            end
            default: begin
               fin_y  = acc_d[2*WIDTH-1:WIDTH];
               fin_of = divz_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         func_q    <= '0;
         x_q       <= '0;
         sel_q     <= '0;
         ld_q      <= 1'b0;
         ld_prev_q <= 1'b0;
         acc_q     <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         divz_q    <= 1'b0;
         y_q       <= '0;
         of_q      <= 1'b0;
         cf_q      <= 1'b0;
         zf_q      <= 1'b1;
         sf_q      <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         ld_q      <= ld;
         ld_prev_q <= ld_q;
         sel_q     <= sel;
         x_q       <= x;
         valid_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // sel/x are sampled together with ld so the write uses the edge-cycle values
               if (ld_q && !ld_prev_q && sel_q != 2'b11) begin
                  case (sel_q)
                     2'b00:   func_q <= x_q[3:0];
                     2'b01:   a_q    <= x_q;
                     default: b_q    <= x_q;
                  endcase
                  state_q <= S_EXEC;
                  busy_q  <= 1'b1;
               end
            end
            S_EXEC: begin
               if (is_multi) begin
                  acc_q   <= (func_q == 4'd12) ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{1'b0}}, a_q};
                  opnd_q  <= (func_q == 4'd12) ? a_q : b_q;
                  divz_q  <= (b_q == '0);
                  cnt_q   <= LAST_CNT;
                  state_q <= S_ITER;
               end else begin
                  y_q     <= fin_y;
                  of_q    <= fin_of;
                  cf_q    <= fin_cf;
                  zf_q    <= (fin_y == '0);
                  sf_q    <= fin_y[WIDTH-1];
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_ITER: begin
               acc_q <= acc_d;
               if (cnt_q == '0) begin
                  y_q     <= fin_y;
                  of_q    <= fin_of;
                  cf_q    <= fin_cf;
                  zf_q    <= (fin_y == '0);
                  sf_q    <= fin_y[WIDTH-1];
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign y     = y_q;
   assign of    = of_q;
   assign cf    = cf_q;
   assign zf    = zf_q;
   assign sf    = sf_q;
   assign busy  = busy_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=6): each accepted load pushes its expected
// valid cycle and, for directed vectors, hand-computed result and flags.
module tb_alu_seq;

   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rstn;
   logic         ld;
   logic [1:0]   sel;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         of, cf, zf, sf, busy, valid;

   typedef struct {
      int           at_cyc;
      bit           chk;
      logic [W-1:0] y;
      logic [3:0]   f;   // {of, cf, zf, sf}
   } exp_t;

   exp_t       sb[$];
   int         cyc = 0;
   int         tests = 0;
   int         fails = 0;
   logic [3:0] func_m = 4'd0;

   alu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .ld    (ld),
      .sel   (sel),
      .x     (x),
      .y     (y),
      .of    (of),
      .cf    (cf),
      .zf    (zf),
      .sf    (sf),
      .busy  (busy),
      .valid (valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit multi(input logic [3:0] f);
      return (f == 4'd12) || (f == 4'd13) || (f == 4'd14);
   endfunction

   // One-cycle ld pulse; returns after the edge where busy must have risen.
   task automatic issue(input logic [1:0] s, input logic [W-1:0] v, input bit chk,
                        input logic [W-1:0] ey, input logic [3:0] ef);
      int n;
      int lat;
      @(negedge clk);
      sel = s; x = v; ld = 1'b1;
      n = cyc + 1;
      if (s == 2'b00) func_m = v[3:0];
      lat = multi(func_m) ? 2 + W : 2;
      if (s != 2'b11) sb.push_back('{n + lat, chk, ey, ef});
      $display("[TB] load sel=%0d x=%02h at edge %0d", s, v, n);
      @(negedge clk);
      ld = 1'b0;
      @(negedge clk);
      check("busy_after_load", busy, (s != 2'b11));
   endtask

   task automatic settle();
      repeat (W + 4) @(negedge clk);
   endtask

   task automatic load(input logic [1:0] s, input logic [W-1:0] v, input bit chk,
                       input logic [W-1:0] ey, input logic [3:0] ef);
      issue(s, v, chk, ey, ef);
      settle();
   endtask

   // Monitor: every valid must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (valid) begin
            $display("[TB] result cycle %0d y=%02h of=%0b cf=%0b zf=%0b sf=%0b",
                     cyc, y, of, cf, zf, sf);
            if (sb.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("valid_cycle", cyc, e.at_cyc);
               check("busy_low_on_valid", busy, 0);
               if (e.chk) begin
                  check("y", y, e.y);
                  check("of", of, e.f[3]);
                  check("cf", cf, e.f[2]);
                  check("zf", zf, e.f[1]);
                  check("sf", sf, e.f[0]);
               end
            end
         end
      end
   end

   initial begin
      rstn = 1'b0; ld = 1'b0; sel = 2'b00; x = '0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("rst_y", y, 0);
      check("rst_zf", zf, 1);
      check("rst_flags", {of, cf, sf}, 0);
      check("rst_busy_valid", {busy, valid}, 0);

      // ADD with signed overflow
      load(2'b00, 6'h00, 0, '0, '0);
      load(2'b01, 6'h1F, 0, '0, '0);
      load(2'b10, 6'h01, 1, 6'h20, 4'b1001);
      // SUB borrow
      load(2'b00, 6'h01, 0, '0, '0);
      load(2'b01, 6'h00, 0, '0, '0);
      load(2'b10, 6'h01, 1, 6'h3F, 4'b0101);
      // EQ
      load(2'b00, 6'h0B, 0, '0, '0);
      load(2'b01, 6'h15, 0, '0, '0);
      load(2'b10, 6'h15, 1, 6'h01, 4'b0000);
      // SRA of 101000 by 2
      load(2'b00, 6'h08, 0, '0, '0);
      load(2'b01, 6'h28, 0, '0, '0);
      load(2'b10, 6'h02, 1, 6'h3A, 4'b0001);
      // SLT: -1 < 2
      load(2'b00, 6'h09, 0, '0, '0);
      load(2'b01, 6'h3F, 1, 6'h01, 4'b0000);
      // sel=11 starts nothing
      load(2'b11, 6'h3F, 0, '0, '0);

      // MUL 7*9, then a dropped load while busy
      load(2'b00, 6'h0C, 0, '0, '0);
      load(2'b01, 6'h07, 0, '0, '0);
      load(2'b10, 6'h09, 1, 6'h3F, 4'b0001);
      issue(2'b10, 6'h09, 1, 6'h3F, 4'b0001);
      repeat (2) @(negedge clk);
      sel = 2'b01; x = 6'h2A; ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
      settle();
      load(2'b10, 6'h09, 1, 6'h3F, 4'b0001);
      // ld held high for 20 cycles counts once
      @(negedge clk);
      sel = 2'b10; x = 6'h09; ld = 1'b1;
      sb.push_back('{cyc + 1 + 2 + W, 1'b1, 6'h3F, 4'b0001});
      repeat (20) @(negedge clk);
      ld = 1'b0;
      settle();
      // MUL 8*8 overflows into the high half
      load(2'b01, 6'h08, 0, '0, '0);
      load(2'b10, 6'h08, 1, 6'h00, 4'b1010);

      // DIVU / REMU, including divide by zero
      load(2'b00, 6'h0D, 0, '0, '0);
      load(2'b01, 6'd45, 0, '0, '0);
      load(2'b10, 6'd7,  1, 6'd6, 4'b0000);
      load(2'b00, 6'h0E, 1, 6'd3, 4'b0000);
      load(2'b10, 6'd0,  1, 6'd45, 4'b1001);
      load(2'b00, 6'h0D, 1, 6'h3F, 4'b1001);

      // Reset during ITER of a MUL: no valid, everything back to reset values
      load(2'b00, 6'h0C, 0, '0, '0);
      @(negedge clk);
      sel = 2'b10; x = 6'h09; ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_before_reset", busy, 1);
      rstn = 1'b0;
      func_m = 4'd0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("mid_rst_y", y, 0);
      check("mid_rst_zf", zf, 1);
      check("mid_rst_flags", {of, cf, sf, busy}, 0);
      settle();
      check("mid_rst_no_result_y", y, 0);
      // func and b were reset, so this is ADD 5+0
      load(2'b01, 6'h05, 1, 6'h05, 4'b0000);

      settle();
      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
